// File: rtl/ram_burst_reader.sv
// Burst read master for a DualPortRam. It issues sequential, wrapping reads and
// streams the returned words on a valid/ready port through a 3-entry buffer.
module ram_burst_reader #(
    parameter int DataWidth = 64,
    parameter int Deepth    = 16,
    parameter int AddrWidth = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 StartValid,
    output logic                 StartReady,
    input  logic [AddrWidth-1:0] StartAddr,
    input  logic [AddrWidth:0]   StartLen,
    input  logic                 Flush,
    output logic [AddrWidth-1:0] RamRAddr,
    output logic                 RamREnc,
    input  logic [DataWidth-1:0] RamRData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [DataWidth-1:0] OutData,
    output logic                 OutLast,
    output logic                 Busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_e;

    localparam int                   BufDepth = 3;
    localparam logic [AddrWidth-1:0] AddrOne  = {{(AddrWidth-1){1'b0}}, 1'b1};
    localparam logic [AddrWidth:0]   LenOne   = {{AddrWidth{1'b0}}, 1'b1};
    localparam logic [AddrWidth:0]   MaxLen   = LenOne << AddrWidth;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [AddrWidth:0]   len_q, len_d;
    logic [AddrWidth:0]   remaining_q, remaining_d;
    logic [AddrWidth:0]   emitted_q, emitted_d;
    logic                 ren_q, ren_d;
    logic                 inflight_q, inflight_d;
    logic [1:0]           count_q, count_d;
    logic [1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0]           rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] buf_q [BufDepth];

    logic                 push, pop, accept, abort;
    logic [AddrWidth:0]   len_clamped;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Read data is only valid the cycle after an issued read.
    assign push        = inflight_q;
    assign pop         = OutValid && OutReady;
    assign accept      = StartValid && StartReady;
    assign abort       = Flush && (state_q != IDLE);
    assign len_clamped = (StartLen > MaxLen) ? MaxLen : StartLen;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path through
        // this block leaves a variable unassigned, which would infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        remaining_d = remaining_q;
        emitted_d   = emitted_q;
        inflight_d  = ren_q;
        wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};

        if (ren_q) begin
            addr_d      = addr_q + AddrOne;
            remaining_d = remaining_q - LenOne;
        end
        if (pop) begin
            emitted_d = emitted_q + LenOne;
        end

        unique case (state_q)
            IDLE: begin
                if (accept && (StartLen != '0)) begin
                    state_d     = READ;
                    addr_d      = StartAddr;
                    len_d       = len_clamped;
                    remaining_d = len_clamped;
                    emitted_d   = '0;
                end
            end
            READ: begin
                if (ren_q && (remaining_q == LenOne)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && OutLast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort drops the buffer and the read still in flight in the RAM.
        if (abort) begin
            state_d     = IDLE;
            addr_d      = '0;
            len_d       = '0;
            remaining_d = '0;
            emitted_d   = '0;
            inflight_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
        end

        // Registered issue decision from next-state values: no path from OutReady to RamREnc.
        ren_d = (state_d == READ) && (remaining_d != '0)
                && (({1'b0, count_d} + {2'b00, inflight_d}) < 3'd3);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            remaining_q <= '0;
            emitted_q   <= '0;
            ren_q       <= 1'b0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            remaining_q <= remaining_d;
            emitted_q   <= emitted_d;
            ren_q       <= ren_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // NOTE: buffer storage is not reset; count_q alone decides which entries
    // are meaningful, and OutData is forced to zero while the buffer is empty.
    always_ff @(posedge Clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= RamRData;
        end
    end

    assign StartReady = (state_q == IDLE) && !Rst && !Flush;
    assign RamRAddr   = addr_q;
    assign RamREnc    = ren_q;
    assign OutValid   = (count_q != 2'd0);
    assign OutData    = OutValid ? buf_q[rd_ptr_q] : '0;
    assign OutLast    = OutValid && (emitted_q == (len_q - LenOne));
    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ram_burst_reader.sv
// Self-checking bench for ram_burst_reader: a behavioural RAM, a queue-based
// reference of each burst, and a monitor that scores every transfer.
module tb_ram_burst_reader;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    logic          Clk;
    logic          Rst;
    logic          StartValid;
    logic          StartReady;
    logic [AW-1:0] StartAddr;
    logic [AW:0]   StartLen;
    logic          Flush;
    logic [AW-1:0] RamRAddr;
    logic          RamREnc;
    logic [DW-1:0] RamRData;
    logic          OutValid;
    logic          OutReady;
    logic [DW-1:0] OutData;
    logic          OutLast;
    logic          Busy;

    logic [DW-1:0] mem [DEPTH];
    word_t         exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int n_vec = 0;
    int n_err = 0;
    int ready_mode = 0;
    int outstanding = 0;
    int burst_acc = 0;
    int burst_iss = 0;
    bit skip_hold = 0;

    ram_burst_reader #(.DataWidth(DW), .Deepth(DEPTH), .AddrWidth(AW)) dut (
        .Clk(Clk), .Rst(Rst),
        .StartValid(StartValid), .StartReady(StartReady),
        .StartAddr(StartAddr), .StartLen(StartLen),
        .Flush(Flush),
        .RamRAddr(RamRAddr), .RamREnc(RamREnc), .RamRData(RamRData),
        .OutValid(OutValid), .OutReady(OutReady),
        .OutData(OutData), .OutLast(OutLast),
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural DualPortRam read port with one cycle of latency.
    always @(posedge Clk) begin
        if (RamREnc) RamRData <= mem[RamRAddr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Consumer readiness, applied a little after the main driver's updates.
    initial begin
        forever begin
            @(posedge Clk);
            #2;
            case (ready_mode)
                0:       OutReady = 1'b1;
                1:       OutReady = ($urandom_range(0, 3) != 0);
                default: OutReady = 1'b0;
            endcase
        end
    end

    // Monitor: scores read addresses, streamed words and output stability.
    initial begin
        bit            prev_hold = 0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;
        word_t         w;
        forever begin
            @(negedge Clk);
            if (skip_hold) begin
                prev_hold = 0;
                skip_hold = 0;
            end
            if (prev_hold) begin
                check("hold_valid", 64'(OutValid), 64'd1);
                check("hold_data", OutData, prev_data);
                check("hold_last", 64'(OutLast), 64'(prev_last));
            end
            prev_hold = OutValid && !OutReady;
            prev_data = OutData;
            prev_last = OutLast;
            if (RamREnc === 1'b1) begin
                outstanding++;
                burst_iss++;
                if (exp_addr_q.size() == 0) fail_now("unexpected_read");
                else check("ram_addr", 64'(RamRAddr), 64'(exp_addr_q.pop_front()));
            end
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                outstanding--;
                burst_acc++;
                if (exp_q.size() == 0) fail_now("unexpected_word");
                else begin
                    w = exp_q.pop_front();
                    check("out_data", OutData, w.data);
                    check("out_last", 64'(OutLast), 64'(w.last));
                end
            end
            if (RamREnc === 1'b1) check("outstanding_le_3", 64'(outstanding <= 3), 64'd1);
        end
    end

    // Issues one command from IDLE and pushes the reference response.
    task automatic do_cmd(input int addr, input int len, output int n);
        @(posedge Clk);
        #1;
        StartValid = 1'b1;
        StartAddr  = AW'(addr);
        StartLen   = (AW + 1)'(len);
        n = (len > DEPTH) ? DEPTH : len;
        for (int k = 0; k < n; k++) begin
            int a;
            a = (addr + k) % DEPTH;
            exp_addr_q.push_back(AW'(a));
            exp_q.push_back('{data: mem[a], last: (k == n - 1)});
        end
        burst_acc = 0;
        burst_iss = 0;
        @(negedge Clk);
        check("start_ready", 64'(StartReady), 64'd1);
        @(posedge Clk);
        #1;
        StartValid = 1'b0;
        if (n != 0) begin
            @(negedge Clk);
            check("ren_after_accept", 64'(RamREnc), 64'd1);
            check("busy_after_accept", 64'(Busy), 64'd1);
            check("start_ready_busy", 64'(StartReady), 64'd0);
            @(negedge Clk);
            check("out_valid_cycle2", 64'(OutValid), 64'd0);
            @(negedge Clk);
            check("out_valid_cycle3", 64'(OutValid), 64'd1);
        end
    endtask

    task automatic wait_idle(input int n);
        int c = 0;
        @(negedge Clk);
        while (Busy && c < 400) begin
            @(negedge Clk);
            c++;
        end
        if (c >= 400) fail_now("idle_timeout");
        check("start_ready_idle", 64'(StartReady), 64'd1);
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("burst_words", 64'(burst_acc), 64'(n));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 64'(Busy), 64'd0);
        check({tag, "_out_valid"}, 64'(OutValid), 64'd0);
        check({tag, "_out_last"}, 64'(OutLast), 64'd0);
        check({tag, "_out_data"}, OutData, 64'd0);
        check({tag, "_ren"}, 64'(RamREnc), 64'd0);
        check({tag, "_raddr"}, 64'(RamRAddr), 64'd0);
        check({tag, "_start_ready"}, 64'(StartReady), 64'd1);
    endtask

    task automatic flush_now();
        int saved;
        saved = ready_mode;
        @(posedge Clk);
        #1;
        ready_mode = 2;
        Flush      = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        outstanding = 0;
        skip_hold   = 1;
        @(negedge Clk);
        check("flush_busy", 64'(Busy), 64'd0);
        check("flush_out_valid", 64'(OutValid), 64'd0);
        check("flush_ren", 64'(RamREnc), 64'd0);
        repeat (3) begin
            @(negedge Clk);
            check("flush_quiet", 64'(OutValid), 64'd0);
        end
        ready_mode = saved;
    endtask

    initial begin
        int n;
        int c;
        Rst = 1'b1; StartValid = 1'b0; StartAddr = '0; StartLen = '0; Flush = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 64'h100 + 64'(i);

        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("start_ready_in_rst", 64'(StartReady), 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        check_reset_values("reset");

        // Basic burst and wrap.
        do_cmd(2, 4, n);  wait_idle(n);
        do_cmd(14, 4, n); wait_idle(n);

        // Backpressure: consumer stalls from before the first word.
        ready_mode = 2;
        do_cmd(0, 8, n);
        repeat (5) @(negedge Clk);
        check("bp_ren_stalled", 64'(RamREnc), 64'd0);
        check("bp_head", OutData, 64'h100);
        ready_mode = 0;
        wait_idle(n);

        // Zero length, then clamp.
        do_cmd(5, 0, n);
        repeat (4) begin
            @(negedge Clk);
            check("zero_busy", 64'(Busy), 64'd0);
            check("zero_ren", 64'(RamREnc), 64'd0);
            check("zero_out_valid", 64'(OutValid), 64'd0);
        end
        do_cmd(3, 20, n); wait_idle(n);

        // Flush in IDLE blocks a simultaneous command and does nothing else.
        @(posedge Clk);
        #1;
        Flush = 1'b1; StartValid = 1'b1; StartAddr = 4'd3; StartLen = 5'd2;
        @(negedge Clk);
        check("flush_idle_start_ready", 64'(StartReady), 64'd0);
        @(posedge Clk);
        #1;
        Flush = 1'b0; StartValid = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            check("flush_idle_busy", 64'(Busy), 64'd0);
        end

        // Flush mid-burst after three words, then a fresh burst.
        do_cmd(0, 8, n);
        c = 0;
        while (burst_acc < 3 && c < 50) begin
            @(negedge Clk);
            c++;
        end
        if (c >= 50) fail_now("flush_wait_timeout");
        flush_now();
        do_cmd(0, 2, n); wait_idle(n);

        // Reset during DRAIN.
        do_cmd(2, 8, n);
        c = 0;
        while (burst_iss < 8 && c < 50) begin
            @(negedge Clk);
            c++;
        end
        if (c >= 50) fail_now("drain_wait_timeout");
        @(posedge Clk);
        #1;
        ready_mode = 2;
        Rst = 1'b1;
        @(negedge Clk);
        check("start_ready_mid_rst", 64'(StartReady), 64'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        outstanding = 0;
        skip_hold   = 1;
        ready_mode  = 0;
        @(negedge Clk);
        check_reset_values("rst_drain");
        do_cmd(2, 4, n); wait_idle(n);

        // Randomised bursts with random backpressure and occasional flushes.
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        ready_mode = 1;
        for (int it = 0; it < 40; it++) begin
            do_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), n);
            if ((it % 6 == 5) && (n != 0)) begin
                repeat ($urandom_range(0, 8)) @(negedge Clk);
                flush_now();
            end else begin
                wait_idle(n);
            end
        end
        ready_mode = 0;
        repeat (4) @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
